// File: rtl/audio_avg_pkg.sv
// audio_avg_pkg: shared states, widths and level-to-bar helper for the audio averager.
package audio_avg_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;
  localparam int SAMPLE_W = 8;
  localparam int MAG_W = 7;
  localparam int LEVEL_W = 4;
  function automatic logic [7:0] level_to_bar(input logic [LEVEL_W-1:0] level);
    logic [8:0] t;
    t = (9'd1 << level) - 9'd1;
    return t[7:0];
  endfunction
endpackage

// File: rtl/audio_level_meter.sv
// audio_level_meter: peak-hold thermometer driven by each window's average.
module audio_level_meter
  import audio_avg_pkg::*;
#(
  parameter int HOLD_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             update,
  input  logic [MAG_W-1:0] avg,
  output logic [7:0]       led_out
);
  localparam int HW = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [LEVEL_W-1:0] disp_level, disp_d, new_level, decayed;
  logic rise;
  always_comb begin
    new_level = (avg == '0) ? '0 : {1'b0, avg[MAG_W-1:MAG_W-3]} + LEVEL_W'(1);
    decayed = disp_level - LEVEL_W'(1);
    rise = new_level >= disp_level;
    disp_d = rise ? new_level : (hold_cnt != '0) ? disp_level : (decayed > new_level) ? decayed : new_level;
    hold_d = rise ? HW'(HOLD_WINDOWS) : (hold_cnt != '0) ? hold_cnt - HW'(1) : hold_cnt;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_level <= '0;
      hold_cnt <= '0;
      led_out <= '0;
    end else if (update) begin
      disp_level <= disp_d;
      hold_cnt <= hold_d;
      led_out <= level_to_bar(disp_d);
    end
  end
endmodule

// File: rtl/audio_avg_scheduler.sv
// audio_avg_scheduler: windowed mean-magnitude averager with LED peak meter and heartbeat.
module audio_avg_scheduler
  import audio_avg_pkg::*;
#(
  parameter int LOG2_N = 8,
  parameter int HOLD_WINDOWS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] input_audio,
  output logic                busy,
  output logic                avg_valid,
  output logic [7:0]          avg_out,
  output logic [7:0]          led_out,
  output logic                led0
);
  localparam int ACC_W = MAG_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] WIN = CNT_W'(1) << LOG2_N;
  state_t state, state_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [CNT_W-1:0] count, count_d;
  logic [SAMPLE_W-1:0] abs_v;
  logic [MAG_W-1:0] mag;
  logic upd, first;
  // -128 has no positive twin; its absolute value stays 0x80 and saturates to 127
  assign abs_v = input_audio[7] ? -input_audio : input_audio;
  assign mag = abs_v[7] ? '1 : abs_v[MAG_W-1:0];
  assign upd = state == UPDATE;
  assign busy = state != IDLE;
  assign first = enable && sample_valid;
  always_comb begin
    state_d = state;
    acc_d = acc;
    count_d = count;
    case (state)
      IDLE: if (enable) begin
        state_d = ACCUM;
        acc_d = '0;
        count_d = '0;
      end
      ACCUM: if (!enable) state_d = IDLE;
      else if (sample_valid) begin
        acc_d = acc + ACC_W'(mag);
        count_d = count + CNT_W'(1);
        state_d = (count_d == WIN) ? UPDATE : ACCUM;
      end
      default: begin
        state_d = enable ? ACCUM : IDLE;
        acc_d = first ? ACC_W'(mag) : '0;
        count_d = first ? CNT_W'(1) : '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc <= '0;
      count <= '0;
      avg_valid <= 1'b0;
      avg_out <= '0;
      led0 <= 1'b0;
    end else begin
      state <= state_d;
      acc <= acc_d;
      count <= count_d;
      avg_valid <= upd;
      if (upd) begin
        avg_out <= {1'b0, acc[ACC_W-1:LOG2_N]};
        led0 <= ~led0;
      end
    end
  end
  audio_level_meter #(.HOLD_WINDOWS(HOLD_WINDOWS)) u_meter (
    .clk(clk),
    .reset_n(reset_n),
    .update(upd),
    .avg(acc[ACC_W-1:LOG2_N]),
    .led_out(led_out)
  );
endmodule

// File: tb/tb_audio_avg_scheduler.sv
// tb_audio_avg_scheduler: directed + random stimulus against a window-level model of the averager.
module tb_audio_avg_scheduler;
  localparam int L2 = 2;
  localparam int WIN = 1 << L2;
  localparam int HOLD = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic sample_valid = 1'b0;
  logic [7:0] input_audio = 8'h00;
  logic busy, avg_valid, led0;
  logic [7:0] avg_out, led_out;
  int n_cmp = 0;
  int n_bad = 0;

  audio_avg_scheduler #(.LOG2_N(L2), .HOLD_WINDOWS(HOLD)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .sample_valid(sample_valid),
    .input_audio(input_audio),
    .busy(busy),
    .avg_valid(avg_valid),
    .avg_out(avg_out),
    .led_out(led_out),
    .led0(led0)
  );

  always #5 clk = ~clk;

  function automatic int magf(input logic [7:0] x);
    int v;
    v = $signed(x);
    v = (v < 0) ? -v : v;
    return (v > 127) ? 127 : v;
  endfunction

  // Window-level model: collect magnitudes, publish mean one cycle after the window fills.
  bit active, fin;
  int win[$];
  int done_sum, a, nl, m_disp, m_hold;
  int exp_avg, exp_led;
  bit exp_valid, exp_led0, exp_busy;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active = 0; fin = 0; win.delete(); done_sum = 0; m_disp = 0; m_hold = 0;
      exp_avg = 0; exp_led = 0; exp_valid = 0; exp_led0 = 0; exp_busy = 0;
    end else begin
      exp_valid = 0;
      if (fin) begin
        a = done_sum / WIN;
        nl = (a == 0) ? 0 : a / 16 + 1;
        exp_avg = a; exp_valid = 1; exp_led0 = !exp_led0;
        if (nl >= m_disp) begin m_disp = nl; m_hold = HOLD; end
        else if (m_hold > 0) m_hold--;
        else m_disp = (m_disp - 1 > nl) ? m_disp - 1 : nl;
        exp_led = (1 << m_disp) - 1;
        fin = 0; active = enable; win.delete();
        if (enable && sample_valid) win.push_back(magf(input_audio));
      end else if (!active) begin
        active = enable; win.delete();
      end else if (!enable) begin
        active = 0; win.delete();
      end else if (sample_valid) begin
        win.push_back(magf(input_audio));
        if (win.size() == WIN) begin
          done_sum = 0;
          foreach (win[i]) done_sum += win[i];
          fin = 1; win.delete();
        end
      end
      exp_busy = active || fin;
    end
  end

  task automatic cmp(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("busy", int'(busy), int'(exp_busy));
    cmp("avg_valid", int'(avg_valid), int'(exp_valid));
    cmp("avg_out", int'(avg_out), exp_avg);
    cmp("led_out", int'(led_out), exp_led);
    cmp("led0", int'(led0), int'(exp_led0));
  end

  task automatic cyc(input bit en, input bit sv, input logic [7:0] aud);
    enable = en; sample_valid = sv; input_audio = aud;
    @(posedge clk); #1;
  endtask

  task automatic window(input logic [7:0] s0, s1, s2, s3);
    cyc(1, 1, s0); cyc(1, 1, s1); cyc(1, 1, s2); cyc(1, 1, s3);
    cyc(1, 0, 8'h00);
  endtask

  logic [7:0] peak_seq [11] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_avg", int'(avg_out), 0);
    cmp("rst_led", int'(led_out), 0);
    reset_n = 1'b1;
    cyc(1, 0, 8'h00);
    window(8'h0F, 8'h0F, 8'h0F, 8'h0F);
    cmp("c0f_valid", int'(avg_valid), 1);
    cmp("c0f_avg", int'(avg_out), 15);
    cmp("c0f_led", int'(led_out), 8'h01);
    cmp("c0f_led0", int'(led0), 1);
    cyc(1, 0, 8'h00);
    cmp("c0f_pulse", int'(avg_valid), 0);
    window(8'h10, 8'hF0, 8'h30, 8'hD0);
    cmp("mix_avg", int'(avg_out), 32);
    cmp("mix_led", int'(led_out), 8'h07);
    window(8'h80, 8'h80, 8'h80, 8'h80);
    cmp("sat_avg", int'(avg_out), 127);
    cmp("sat_led", int'(led_out), 8'hFF);
    cyc(1, 1, 8'h7F); cyc(1, 1, 8'h7F); cyc(0, 0, 8'h00);
    cmp("abort_busy", int'(busy), 0);
    repeat (3) begin
      cyc(0, 1, 8'h55);
      cmp("abort_valid", int'(avg_valid), 0);
    end
    cmp("abort_avg", int'(avg_out), 127);
    cmp("abort_led", int'(led_out), 8'hFF);
    cyc(1, 0, 8'h00);
    window(8'h20, 8'h20, 8'h20, 8'h20);
    cmp("reen_avg", int'(avg_out), 32);
    cyc(1, 1, 8'h08); cyc(1, 1, 8'h08); cyc(1, 1, 8'h08); cyc(1, 1, 8'h08);
    cyc(0, 0, 8'h00);
    cmp("updlow_valid", int'(avg_valid), 1);
    cmp("updlow_avg", int'(avg_out), 8);
    cmp("updlow_busy", int'(busy), 0);
    cyc(1, 0, 8'h00);
    repeat (13) cyc(1, 1, 8'h40);
    cmp("b2b_avg", int'(avg_out), 64);
    cyc(1, 1, 8'h40); cyc(1, 1, 8'h40);
    #3 reset_n = 1'b0;
    #1;
    cmp("mid_rst_busy", int'(busy), 0);
    cmp("mid_rst_avg", int'(avg_out), 0);
    cmp("mid_rst_led", int'(led_out), 0);
    cmp("mid_rst_led0", int'(led0), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    cyc(1, 0, 8'h00);
    window(8'h81, 8'h81, 8'h81, 8'h81);
    cmp("peak_0", int'(led_out), int'(peak_seq[0]));
    for (int k = 1; k < 11; k++) begin
      window(8'h00, 8'h00, 8'h00, 8'h00);
      cmp($sformatf("peak_%0d", k), int'(led_out), int'(peak_seq[k]));
    end
    repeat (3000) cyc($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)), 8'($urandom));
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
